// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/branch/memory handshake and debug counters between core and sequencer
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
  logic hazard, branch_taken, mem_r_en, mem_w_en;
  logic freeze_if, flush_if, freeze_pipe, flush_id, mem_busy, mem_ready;
  logic [CNT_W-1:0] stall_count, flush_count;
  modport master(output hazard, branch_taken, mem_r_en, mem_w_en,
                 input freeze_if, flush_if, freeze_pipe, flush_id, mem_busy, mem_ready, stall_count, flush_count);
  modport slave(input hazard, branch_taken, mem_r_en, mem_w_en,
                output freeze_if, flush_if, freeze_pipe, flush_id, mem_busy, mem_ready, stall_count, flush_count);
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: freeze/flush sequencing with memory wait-state FSM and saturating debug counters
module pipeline_ctrl #(
  parameter int MEM_WAIT = 4,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipeline_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t r_state, w_state;
  logic [7:0] r_wcnt, w_wcnt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic w_req, w_stall;
  assign w_req = bus.mem_r_en | bus.mem_w_en;
  always_comb begin
    w_state = r_state;
    w_wcnt = r_wcnt;
    case (r_state)
      IDLE: if (w_req) begin
        w_state = ACCESS;
        w_wcnt = 8'(MEM_WAIT - 2);
      end
      ACCESS: if (r_wcnt == 8'd0) w_state = DONE; else w_wcnt = r_wcnt - 8'd1;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wcnt <= 8'd0;
    end else begin
      r_state <= w_state;
      r_wcnt <= w_wcnt;
    end
  end
  // memory stall outranks branch, which outranks hazard; everything is quiet under reset
  assign w_stall = ~rst & (((r_state == IDLE) & w_req) | (r_state == ACCESS));
  assign bus.mem_busy = w_stall;
  assign bus.freeze_pipe = w_stall;
  assign bus.mem_ready = ~rst & (r_state == DONE);
  assign bus.freeze_if = w_stall | (~rst & bus.hazard & ~bus.branch_taken);
  assign bus.flush_if = ~rst & bus.branch_taken & ~w_stall;
  assign bus.flush_id = ~rst & (bus.branch_taken | bus.hazard) & ~w_stall;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (bus.freeze_if && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (bus.flush_if && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scenario tasks with a queued per-cycle strobe scoreboard and counter model
module tb_pipeline_ctrl;
  logic clk = 0, rst = 1;
  logic hz = 0, br = 0, rd = 0, wr = 0, rd2 = 0;
  int n_cmp = 0, n_err = 0;
  int exp_stall = 0, exp_flush = 0;
  logic [5:0] q[$];
  logic [5:0] e;
  always #5 clk = ~clk;
  pipeline_ctrl_if #(.CNT_W(16)) m();
  pipeline_ctrl_if #(.CNT_W(4)) s4();
  pipeline_ctrl_if #(.CNT_W(16)) s2();
  assign m.hazard = hz;
  assign m.branch_taken = br;
  assign m.mem_r_en = rd;
  assign m.mem_w_en = wr;
  assign s4.hazard = hz;
  assign s4.branch_taken = br;
  assign s4.mem_r_en = rd;
  assign s4.mem_w_en = wr;
  assign s2.hazard = 1'b0;
  assign s2.branch_taken = 1'b0;
  assign s2.mem_r_en = rd2;
  assign s2.mem_w_en = 1'b0;
  pipeline_ctrl #(.MEM_WAIT(4), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(m.slave));
  pipeline_ctrl #(.MEM_WAIT(4), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(s4.slave));
  pipeline_ctrl #(.MEM_WAIT(2), .CNT_W(16)) dut2 (.clk(clk), .rst(rst), .bus(s2.slave));
  // strobe vector order: freeze_if, flush_if, freeze_pipe, flush_id, mem_busy, mem_ready
  wire [5:0] w_out = {m.freeze_if, m.flush_if, m.freeze_pipe, m.flush_id, m.mem_busy, m.mem_ready};
  wire [5:0] w_out4 = {s4.freeze_if, s4.flush_if, s4.freeze_pipe, s4.flush_id, s4.mem_busy, s4.mem_ready};
  wire [5:0] w_out2 = {s2.freeze_if, s2.flush_if, s2.freeze_pipe, s2.flush_id, s2.mem_busy, s2.mem_ready};
  function automatic int sat15(input int v);
    return v > 15 ? 15 : v;
  endfunction
  task automatic test_reset;
    rst = 1; {hz, br, rd, wr} = 4'hf; rd2 = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (w_out !== 6'd0) begin n_err++; $display("FAIL reset_strobes[%0d] got=%b exp=000000", i, w_out); end
      n_cmp++; if (w_out4 !== 6'd0) begin n_err++; $display("FAIL reset_strobes4[%0d] got=%b exp=000000", i, w_out4); end
      n_cmp++; if (w_out2 !== 6'd0) begin n_err++; $display("FAIL reset_strobes2[%0d] got=%b exp=000000", i, w_out2); end
    end
    @(posedge clk); #1;
    rst = 0; {hz, br, rd, wr} = 4'h0; rd2 = 0;
    @(negedge clk);
    n_cmp++; if (w_out !== 6'd0) begin n_err++; $display("FAIL post_reset_strobes got=%b exp=000000", w_out); end
    n_cmp++; if (m.stall_count !== 16'd0 || m.flush_count !== 16'd0) begin n_err++; $display("FAIL post_reset_counts got=%0d/%0d exp=0/0", m.stall_count, m.flush_count); end
    n_cmp++; if (s4.stall_count !== 4'd0 || s2.stall_count !== 16'd0) begin n_err++; $display("FAIL post_reset_counts_aux got=%0d/%0d exp=0/0", s4.stall_count, s2.stall_count); end
    exp_stall = 0; exp_flush = 0;
  endtask
  task automatic test_wait2;
    logic st[4] = '{1, 1, 1, 0};
    logic [5:0] ex[4] = '{6'b101010, 6'b101010, 6'b000001, 6'b000000};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rd2 = st[i]; q.push_back(ex[i]);
      @(negedge clk); e = q.pop_front();
      n_cmp++; if (w_out2 !== e) begin n_err++; $display("FAIL wait2[%0d] got=%b exp=%b", i, w_out2, e); end
    end
    n_cmp++; if (s2.stall_count !== 16'd2) begin n_err++; $display("FAIL wait2_stall_count got=%0d exp=2", s2.stall_count); end
  endtask
  task automatic run_seq(input string nm, input logic [3:0] st[], input logic [5:0] ex[], output int pulses);
    pulses = 0;
    for (int i = 0; i < st.size(); i++) begin
      @(posedge clk); #1;
      {hz, br, rd, wr} = st[i]; q.push_back(ex[i]);
      @(negedge clk); e = q.pop_front();
      n_cmp++; if (w_out !== e) begin n_err++; $display("FAIL %s[%0d] got=%b exp=%b", nm, i, w_out, e); end
      n_cmp++; if (m.stall_count !== 16'(exp_stall) || m.flush_count !== 16'(exp_flush)) begin
        n_err++; $display("FAIL %s_counts[%0d] got=%0d/%0d exp=%0d/%0d", nm, i, m.stall_count, m.flush_count, exp_stall, exp_flush);
      end
      pulses += int'(m.mem_ready);
      exp_stall += int'(e[5]); exp_flush += int'(e[4]);
    end
  endtask
  task automatic test_single_load;
    logic [3:0] st[] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic [5:0] ex[] = '{6'b101010, 6'b101010, 6'b101010, 6'b101010, 6'b000001, 6'b000000};
    int p;
    int base = exp_stall;
    run_seq("single_load", st, ex, p);
    n_cmp++; if (m.stall_count !== 16'(base + 4)) begin n_err++; $display("FAIL single_load_stall got=%0d exp=%0d", m.stall_count, base + 4); end
  endtask
  task automatic test_back_to_back;
    logic [3:0] st[] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    logic [5:0] ex[] = '{6'b101010, 6'b101010, 6'b101010, 6'b101010, 6'b000001,
                         6'b101010, 6'b101010, 6'b101010, 6'b101010, 6'b000001, 6'b000000};
    int p;
    run_seq("back_to_back", st, ex, p);
    n_cmp++; if (p !== 2) begin n_err++; $display("FAIL back_to_back_pulses got=%0d exp=2", p); end
  endtask
  task automatic test_branch_stall;
    logic [3:0] st[] = '{4'b0010, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0000};
    logic [5:0] ex[] = '{6'b101010, 6'b101010, 6'b101010, 6'b101010, 6'b010101, 6'b000000};
    int p;
    run_seq("branch_stall", st, ex, p);
  endtask
  task automatic test_hazard;
    logic [3:0] st[] = '{4'b1000, 4'b1100, 4'b0100, 4'b1000, 4'b0000};
    logic [5:0] ex[] = '{6'b100100, 6'b010100, 6'b010100, 6'b100100, 6'b000000};
    int p;
    run_seq("hazard", st, ex, p);
  endtask
  task automatic test_reset_mid_access;
    logic [4:0] st[5] = '{5'b00010, 5'b00010, 5'b10010, 5'b00000, 5'b00000};
    logic [5:0] ex[5] = '{6'b101010, 6'b101010, 6'b000000, 6'b000000, 6'b000000};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      {rst, hz, br, rd, wr} = st[i]; q.push_back(ex[i]);
      @(negedge clk); e = q.pop_front();
      n_cmp++; if (w_out !== e) begin n_err++; $display("FAIL reset_mid[%0d] got=%b exp=%b", i, w_out, e); end
      n_cmp++; if (m.stall_count !== 16'(exp_stall) || m.flush_count !== 16'(exp_flush)) begin
        n_err++; $display("FAIL reset_mid_counts[%0d] got=%0d/%0d exp=%0d/%0d", i, m.stall_count, m.flush_count, exp_stall, exp_flush);
      end
      exp_stall += int'(e[5]); exp_flush += int'(e[4]);
      if (st[i][4]) begin exp_stall = 0; exp_flush = 0; end
    end
  endtask
  task automatic test_saturation;
    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      {hz, br, rd, wr} = (i < 20) ? 4'b1000 : 4'b0000;
      q.push_back((i < 20) ? 6'b100100 : 6'b000000);
      @(negedge clk); e = q.pop_front();
      n_cmp++; if (w_out4 !== e) begin n_err++; $display("FAIL saturation[%0d] got=%b exp=%b", i, w_out4, e); end
      n_cmp++; if (s4.stall_count !== 4'(sat15(exp_stall)) || s4.flush_count !== 4'(sat15(exp_flush))) begin
        n_err++; $display("FAIL saturation_counts[%0d] got=%0d/%0d exp=%0d/%0d", i, s4.stall_count, s4.flush_count, sat15(exp_stall), sat15(exp_flush));
      end
      n_cmp++; if (m.stall_count !== 16'(exp_stall)) begin n_err++; $display("FAIL saturation_wide[%0d] got=%0d exp=%0d", i, m.stall_count, exp_stall); end
      exp_stall += int'(e[5]); exp_flush += int'(e[4]);
    end
    n_cmp++; if (s4.stall_count !== 4'd15) begin n_err++; $display("FAIL saturation_final got=%0d exp=15", s4.stall_count); end
  endtask
  initial begin
    test_reset;
    test_wait2;
    test_single_load;
    test_back_to_back;
    test_branch_stall;
    test_hazard;
    test_reset_mid_access;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
